// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared defaults and FSM state encoding for uart_frame_loader.
//   DEF_HEADER_BYTE    - frame start marker
//   DEF_PAYLOAD_BYTES  - payload length in bytes (16 columns x 2 bytes)
//   DEF_TIMEOUT_CYCLES - maximum inter-byte gap inside a frame
//   state_t            - loader FSM states
package uart_frame_pkg;

  localparam logic [7:0]  DEF_HEADER_BYTE    = 8'hA5;
  localparam int unsigned DEF_PAYLOAD_BYTES  = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 500000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CSUM    = 2'd2
  } state_t;

endpackage

// File: rtl/uart_frame_loader_timer.sv
// frame_timer: inter-byte gap timer.
//   i_clk_sys - system clock
//   i_rst     - synchronous active-high reset
//   i_clear   - restart the count from zero (has priority over i_enable)
//   i_enable  - count one per cycle while high
//   o_expired - high while enabled and the count has reached TIMEOUT_CYCLES-1
module frame_timer
  import uart_frame_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic i_clk_sys,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned     TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]   LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_cnt;

  // Count holds at LAST so it can never wrap back into the valid range.
  always_ff @(posedge i_clk_sys) begin
    if (i_rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/uart_frame_loader.sv
// uart_frame_loader: assembles HEADER + PAYLOAD_BYTES + checksum frames from a
// UART byte stream into a double-buffered display memory.
//   i_clk_sys   - system clock
//   i_rst       - synchronous active-high reset
//   i_rx_data   - received byte, qualified by i_rx_valid
//   i_rx_valid  - one-cycle byte strobe
//   i_rx_perr   - parity error flag for the current byte
//   i_rd_col    - display column to read
//   o_rd_data   - {byte[2*col], byte[2*col+1]} of the committed bank (combinational)
//   o_frame_ok  - one-cycle pulse on frame commit
//   o_frame_err - one-cycle pulse on frame rejection (checksum, parity, timeout)
//   o_busy      - frame in progress
//   o_frame_cnt - committed frame count, wrapping
module uart_frame_loader
  import uart_frame_pkg::*;
#(
  parameter logic [7:0]  HEADER_BYTE    = DEF_HEADER_BYTE,
  parameter int unsigned PAYLOAD_BYTES  = DEF_PAYLOAD_BYTES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        i_clk_sys,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_rx_perr,
  input  logic [3:0]  i_rd_col,
  output logic [15:0] o_rd_data,
  output logic        o_frame_ok,
  output logic        o_frame_err,
  output logic        o_busy,
  output logic [7:0]  o_frame_cnt
);

  localparam int unsigned   IW       = $clog2(PAYLOAD_BYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(PAYLOAD_BYTES - 1);

  state_t        r_state, w_state_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic [7:0]    r_sum, w_sum_nxt;
  logic          r_eflag, w_eflag_nxt;
  logic          r_bank_sel;
  logic          r_frame_ok, r_frame_err;
  logic [7:0]    r_frame_cnt;
  logic [7:0]    r_bank [0:1][0:PAYLOAD_BYTES-1];

  logic          w_wr_en, w_ok_nxt, w_err_nxt;
  logic          w_expired, w_busy;
  logic [IW-1:0] w_rd_idx0, w_rd_idx1;

  assign w_busy = (r_state != ST_IDLE);

  // The timer is held clear in IDLE so every frame starts counting from zero.
  frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk_sys(i_clk_sys),
    .i_rst    (i_rst),
    .i_clear  (i_rx_valid || !w_busy),
    .i_enable (w_busy),
    .o_expired(w_expired)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_sum_nxt   = r_sum;
    w_eflag_nxt = r_eflag;
    w_wr_en     = 1'b0;
    w_ok_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_rx_valid && !i_rx_perr && (i_rx_data == HEADER_BYTE)) begin
          w_state_nxt = ST_PAYLOAD;
          w_idx_nxt   = '0;
          w_sum_nxt   = '0;
          w_eflag_nxt = 1'b0;
        end
      end
      ST_PAYLOAD: begin
        // A valid byte always beats a coincident timeout.
        if (i_rx_valid) begin
          w_wr_en     = 1'b1;
          w_sum_nxt   = r_sum + i_rx_data;
          w_eflag_nxt = r_eflag | i_rx_perr;
          if (r_idx == LAST_IDX) begin
            w_state_nxt = ST_CSUM;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else if (w_expired) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 1'b1;
        end
      end
      ST_CSUM: begin
        if (i_rx_valid) begin
          w_state_nxt = ST_IDLE;
          if ((i_rx_data == r_sum) && !i_rx_perr && !r_eflag) begin
            w_ok_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if (w_expired) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_sum       <= '0;
      r_eflag     <= 1'b0;
      r_bank_sel  <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_frame_cnt <= '0;
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned i = 0; i < PAYLOAD_BYTES; i++) begin
          r_bank[b][i] <= '0;
        end
      end
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_sum       <= w_sum_nxt;
      r_eflag     <= w_eflag_nxt;
      r_frame_ok  <= w_ok_nxt;
      r_frame_err <= w_err_nxt;
      if (w_ok_nxt) begin
        r_bank_sel  <= ~r_bank_sel;
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
      // Writes only ever touch the uncommitted bank.
      if (w_wr_en) begin
        r_bank[~r_bank_sel][r_idx] <= i_rx_data;
      end
    end
  end

  assign w_rd_idx0   = IW'({i_rd_col, 1'b0});
  assign w_rd_idx1   = IW'({i_rd_col, 1'b1});
  assign o_rd_data   = {r_bank[r_bank_sel][w_rd_idx0], r_bank[r_bank_sel][w_rd_idx1]};
  assign o_frame_ok  = r_frame_ok;
  assign o_frame_err = r_frame_err;
  assign o_busy      = w_busy;
  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_uart_frame_loader.sv
// tb_uart_frame_loader: scoreboard bench for uart_frame_loader with a short timeout.
module tb_uart_frame_loader;

  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_perr = 1'b0;
  logic [3:0]  rd_col = '0;
  logic [15:0] rd_data;
  logic        frame_ok, frame_err, busy;
  logic [7:0]  frame_cnt;

  int checks = 0;
  int errors = 0;

  // Expected outcome of each frame (1 = commit, 0 = reject), in order.
  logic       exp_q [$];
  logic [7:0] committed [32];
  logic [7:0] tx_payload [32];
  logic [7:0] cnt_exp = '0;

  uart_frame_loader #(
    .HEADER_BYTE   (8'hA5),
    .PAYLOAD_BYTES (32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk_sys  (clk),
    .i_rst      (rst),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .i_rx_perr  (rx_perr),
    .i_rd_col   (rd_col),
    .o_rd_data  (rd_data),
    .o_frame_ok (frame_ok),
    .o_frame_err(frame_err),
    .o_busy     (busy),
    .o_frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every ok/err pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_ok && frame_err) begin
        checks++; errors++;
        $display("FAIL ok_err_exclusive: ok=%0b err=%0b required not both", frame_ok, frame_err);
      end else if (frame_ok || frame_err) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: ok=%0b err=%0b required no pulse", frame_ok, frame_err);
        end else begin
          logic e;
          e = exp_q.pop_front();
          if (frame_ok !== e) begin
            errors++;
            $display("FAIL frame_outcome: ok=%0b err=%0b required ok=%0b", frame_ok, frame_err, e);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic p);
    @(posedge clk); #1;
    rx_data = d; rx_valid = 1'b1; rx_perr = p;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_perr = 1'b0;
  endtask

  // Sends header, tx_payload and csum; optional parity error on one byte and
  // optional idle gap before one byte. Updates the model when the frame should commit.
  task automatic send_frame(input logic [7:0] csum, input int perr_idx,
                            input int gap_idx, input int gap);
    logic [7:0] s;
    logic       good;
    s = '0;
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 32; i++) begin
      if (i == gap_idx) repeat (gap) @(posedge clk);
      send_byte(tx_payload[i], i == perr_idx);
      s = s + tx_payload[i];
    end
    good = (csum == s) && (perr_idx < 0);
    exp_q.push_back(good);
    send_byte(csum, 1'b0);
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL frame_pulse_timeout: pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    if (good) begin
      committed = tx_payload;
      cnt_exp = cnt_exp + 8'd1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({frame_ok, frame_err, busy, frame_cnt} !== 11'b0) begin
      errors++;
      $display("FAIL reset_outputs: ok=%0b err=%0b busy=%0b cnt=%0d required 0", frame_ok, frame_err, busy, frame_cnt);
    end
    for (int c = 0; c < 16; c++) begin
      rd_col = 4'(c); #1;
      checks++;
      if (rd_data !== 16'h0000) begin
        errors++;
        $display("FAIL reset_rd_data col=%0d: got %h required 0000", c, rd_data);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 32; i++) committed[i] = '0;
  endtask

  task automatic test_good_frame;
    for (int i = 0; i < 32; i++) tx_payload[i] = 8'(i);
    send_frame(8'hF0, -1, -1, 0);
    checks++;
    if (frame_cnt !== 8'd1) begin
      errors++; $display("FAIL good_cnt: got %0d required 1", frame_cnt);
    end
    rd_col = 4'd0; #1;
    checks++;
    if (rd_data !== 16'h0001) begin
      errors++; $display("FAIL good_col0: got %h required 0001", rd_data);
    end
    rd_col = 4'd15; #1;
    checks++;
    if (rd_data !== 16'h1E1F) begin
      errors++; $display("FAIL good_col15: got %h required 1E1F", rd_data);
    end
  endtask

  task automatic test_bad_csum;
    for (int i = 0; i < 32; i++) tx_payload[i] = 8'h40 + 8'(i);
    send_frame(8'hF1, -1, -1, 0);
    checks++;
    if (frame_cnt !== cnt_exp) begin
      errors++; $display("FAIL bad_csum_cnt: got %0d required %0d", frame_cnt, cnt_exp);
    end
    for (int c = 0; c < 16; c++) begin
      rd_col = 4'(c); #1;
      checks++;
      if (rd_data !== {committed[2*c], committed[2*c+1]}) begin
        errors++;
        $display("FAIL bad_csum_rd col=%0d: got %h required %h", c, rd_data, {committed[2*c], committed[2*c+1]});
      end
    end
  endtask

  task automatic test_timeout;
    int waited;
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 10; i++) send_byte(8'(i + 7), 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL timeout_busy_before: got %0b required 1", busy);
    end
    exp_q.push_back(1'b0);
    waited = 0;
    while (exp_q.size() != 0 && waited < TO + 20) begin
      @(posedge clk); waited++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL timeout_pulse: pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL timeout_busy_after: got %0b required 0", busy);
    end
    for (int i = 0; i < 32; i++) tx_payload[i] = 8'(i * 3);
    send_frame(8'(16'd1488), -1, -1, 0);
    checks++;
    if (frame_cnt !== cnt_exp) begin
      errors++; $display("FAIL timeout_fresh_cnt: got %0d required %0d", frame_cnt, cnt_exp);
    end
    rd_col = 4'd15; #1;
    checks++;
    if (rd_data !== {8'd90, 8'd93}) begin
      errors++; $display("FAIL timeout_fresh_col15: got %h required 5A5D", rd_data);
    end
  endtask

  task automatic test_perr;
    logic [7:0] s;
    send_byte(8'h33, 1'b0);
    send_byte(8'hA5, 1'b1);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL idle_ignore_busy: got %0b required 0", busy);
    end
    s = '0;
    for (int i = 0; i < 32; i++) begin
      tx_payload[i] = 8'hC0 ^ 8'(i);
      s = s + tx_payload[i];
    end
    send_frame(s, 5, -1, 0);
    checks++;
    if (frame_cnt !== cnt_exp) begin
      errors++; $display("FAIL perr_cnt: got %0d required %0d", frame_cnt, cnt_exp);
    end
    rd_col = 4'd2; #1;
    checks++;
    if (rd_data !== {committed[4], committed[5]}) begin
      errors++; $display("FAIL perr_rd: got %h required %h", rd_data, {committed[4], committed[5]});
    end
  endtask

  task automatic test_all_a5;
    for (int i = 0; i < 32; i++) tx_payload[i] = 8'hA5;
    send_frame(8'hA0, -1, -1, 0);
    checks++;
    if (frame_cnt !== cnt_exp) begin
      errors++; $display("FAIL a5_cnt: got %0d required %0d", frame_cnt, cnt_exp);
    end
    for (int c = 0; c < 16; c++) begin
      rd_col = 4'(c); #1;
      checks++;
      if (rd_data !== 16'hA5A5) begin
        errors++; $display("FAIL a5_col col=%0d: got %h required A5A5", c, rd_data);
      end
    end
  endtask

  // Gap of TO-2 idle edges puts the next byte exactly on the expiry cycle.
  task automatic test_byte_wins;
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < 32; i++) begin
      tx_payload[i] = 8'h5A ^ 8'(i * 5);
      s = s + tx_payload[i];
    end
    send_frame(s, -1, 7, TO - 2);
    checks++;
    if (frame_cnt !== cnt_exp) begin
      errors++; $display("FAIL byte_wins_cnt: got %0d required %0d", frame_cnt, cnt_exp);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] s;
    for (int f = 0; f < 2; f++) begin
      s = '0;
      for (int i = 0; i < 32; i++) begin
        tx_payload[i] = 8'(i * 7 + f * 11 + 1);
        s = s + tx_payload[i];
      end
      send_frame(s, -1, -1, 0);
      for (int c = 0; c < 16; c += 5) begin
        rd_col = 4'(c); #1;
        checks++;
        if (rd_data !== {committed[2*c], committed[2*c+1]}) begin
          errors++;
          $display("FAIL b2b_rd f=%0d col=%0d: got %h required %h", f, c, rd_data, {committed[2*c], committed[2*c+1]});
        end
      end
    end
    checks++;
    if (frame_cnt !== cnt_exp) begin
      errors++; $display("FAIL b2b_cnt: got %0d required %0d", frame_cnt, cnt_exp);
    end
  endtask

  task automatic test_reset_midframe;
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 20; i++) send_byte(8'(i + 100), 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({frame_ok, frame_err, busy, frame_cnt} !== 11'b0) begin
      errors++;
      $display("FAIL midreset_outputs: ok=%0b err=%0b busy=%0b cnt=%0d required 0", frame_ok, frame_err, busy, frame_cnt);
    end
    for (int c = 0; c < 16; c++) begin
      rd_col = 4'(c); #1;
      checks++;
      if (rd_data !== 16'h0000) begin
        errors++; $display("FAIL midreset_rd col=%0d: got %h required 0000", c, rd_data);
      end
    end
    rst = 1'b0;
    cnt_exp = '0;
    repeat (TO + 10) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || frame_cnt !== 8'd0) begin
      errors++; $display("FAIL midreset_after: busy=%0b cnt=%0d required 0 0", busy, frame_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_bad_csum;
    test_timeout;
    test_perr;
    test_all_a5;
    test_byte_wins;
    test_back_to_back;
    test_reset_midframe;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: pending=%0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
